// File: rtl/lcd_write_sequencer.sv
// Sequences one byte write to the Spartan-3E character LCD over its 4-bit bus:
// upper nibble, enable pulse, 1 us gap, lower nibble, enable pulse, execution delay.
module lcd_write_sequencer #(
    parameter int GAP_NIBBLE_CYCLES = 50,
    parameter int GAP_EXEC_CYCLES   = 2000,
    parameter int GAP_CLEAR_CYCLES  = 82000,
    parameter int ENABLE_TIMEOUT    = 64
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iRS,
    input  logic       iWriteRequest,
    output logic       oReady,
    output logic       oWriteDone,
    output logic       oError,
    output logic [3:0] oLCD_Data,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic       oEnableGenReset,
    input  logic       iEnableDone,
    output logic [3:0] oDebugState
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_SETUP_HI = 4'd1;
    localparam logic [3:0] S_PULSE_HI = 4'd2;
    localparam logic [3:0] S_GAP_HI   = 4'd3;
    localparam logic [3:0] S_SETUP_LO = 4'd4;
    localparam logic [3:0] S_PULSE_LO = 4'd5;
    localparam logic [3:0] S_GAP_EXEC = 4'd6;
    localparam logic [3:0] S_DONE     = 4'd7;
    localparam logic [3:0] S_ABORT    = 4'd8;

    logic [3:0]  r_state;
    logic [31:0] r_count;
    logic [7:0]  r_data;
    logic        r_rs;

    logic [31:0] w_count_next;
    logic        w_is_clear;
    logic [31:0] w_exec_limit;

    // Clear display / return home need the long execution delay.
    assign w_count_next = r_count + 32'd1;
    assign w_is_clear   = !r_rs && ((r_data == 8'h01) || (r_data == 8'h02));
    assign w_exec_limit = w_is_clear ? 32'(GAP_CLEAR_CYCLES) : 32'(GAP_EXEC_CYCLES);
    assign oDebugState  = r_state;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state         <= S_IDLE;
            r_count         <= 32'd0;
            r_data          <= 8'h00;
            r_rs            <= 1'b0;
            oReady          <= 1'b1;
            oWriteDone      <= 1'b0;
            oError          <= 1'b0;
            oLCD_Data       <= 4'h0;
            oLCD_RS         <= 1'b0;
            oLCD_RW         <= 1'b0;
            oEnableGenReset <= 1'b1;
        end else begin
            oWriteDone <= 1'b0;
            oError     <= 1'b0;
            oLCD_RW    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (iWriteRequest) begin
                        r_data    <= iData;
                        r_rs      <= iRS;
                        oLCD_Data <= iData[7:4];
                        oLCD_RS   <= iRS;
                        oReady    <= 1'b0;
                        r_count   <= 32'd0;
                        r_state   <= S_SETUP_HI;
                    end
                end
                S_SETUP_HI: begin
                    oEnableGenReset <= 1'b0;
                    r_count         <= 32'd0;
                    r_state         <= S_PULSE_HI;
                end
                S_PULSE_HI: begin
                    // Re-hold the generator on the done edge so it cannot fire twice.
                    if (iEnableDone) begin
                        oEnableGenReset <= 1'b1;
                        r_count         <= 32'd0;
                        r_state         <= S_GAP_HI;
                    end else if (w_count_next >= 32'(ENABLE_TIMEOUT)) begin
                        oEnableGenReset <= 1'b1;
                        oError          <= 1'b1;
                        oLCD_Data       <= 4'h0;
                        r_count         <= 32'd0;
                        r_state         <= S_ABORT;
                    end else begin
                        r_count <= w_count_next;
                    end
                end
                S_GAP_HI: begin
                    if (w_count_next >= 32'(GAP_NIBBLE_CYCLES)) begin
                        oLCD_Data <= r_data[3:0];
                        r_count   <= 32'd0;
                        r_state   <= S_SETUP_LO;
                    end else begin
                        r_count <= w_count_next;
                    end
                end
                S_SETUP_LO: begin
                    oEnableGenReset <= 1'b0;
                    r_count         <= 32'd0;
                    r_state         <= S_PULSE_LO;
                end
                S_PULSE_LO: begin
                    if (iEnableDone) begin
                        oEnableGenReset <= 1'b1;
                        r_count         <= 32'd0;
                        r_state         <= S_GAP_EXEC;
                    end else if (w_count_next >= 32'(ENABLE_TIMEOUT)) begin
                        oEnableGenReset <= 1'b1;
                        oError          <= 1'b1;
                        oLCD_Data       <= 4'h0;
                        r_count         <= 32'd0;
                        r_state         <= S_ABORT;
                    end else begin
                        r_count <= w_count_next;
                    end
                end
                S_GAP_EXEC: begin
                    if (w_count_next >= w_exec_limit) begin
                        oWriteDone <= 1'b1;
                        r_count    <= 32'd0;
                        r_state    <= S_DONE;
                    end else begin
                        r_count <= w_count_next;
                    end
                end
                S_DONE: begin
                    oReady  <= 1'b1;
                    r_count <= 32'd0;
                    r_state <= S_IDLE;
                end
                S_ABORT: begin
                    oReady  <= 1'b1;
                    r_count <= 32'd0;
                    r_state <= S_IDLE;
                end
                default: begin
                    oReady          <= 1'b1;
                    oEnableGenReset <= 1'b1;
                    r_count         <= 32'd0;
                    r_state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Directed bench for lcd_write_sequencer with a behavioural Module_Write_Enable model.
module tb_lcd_write_sequencer;

  localparam int NIBBLE  = 50;
  localparam int EXEC    = 200;
  localparam int CLEAR   = 1000;
  localparam int TIMEOUT = 64;
  localparam int BUDGET  = 3000;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] iData = 8'h00;
  logic       iRS = 1'b0;
  logic       iWriteRequest = 1'b0;
  logic       iEnableDone = 1'b0;
  logic       oReady, oWriteDone, oError, oLCD_RS, oLCD_RW, oEnableGenReset;
  logic [3:0] oLCD_Data;
  logic [3:0] oDebugState;

  int checks = 0;
  int errors = 0;

  lcd_write_sequencer #(
    .GAP_NIBBLE_CYCLES(NIBBLE),
    .GAP_EXEC_CYCLES(EXEC),
    .GAP_CLEAR_CYCLES(CLEAR),
    .ENABLE_TIMEOUT(TIMEOUT)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .iData(iData),
    .iRS(iRS),
    .iWriteRequest(iWriteRequest),
    .oReady(oReady),
    .oWriteDone(oWriteDone),
    .oError(oError),
    .oLCD_Data(oLCD_Data),
    .oLCD_RS(oLCD_RS),
    .oLCD_RW(oLCD_RW),
    .oEnableGenReset(oEnableGenReset),
    .iEnableDone(iEnableDone),
    .oDebugState(oDebugState)
  );

  // clock / reset
  always #5 Clock = ~Clock;

  // enable generator model: enable rises 4 cycles after release, done after 12
  bit         tie_low = 1'b0;
  int         gen_cnt = 0;
  logic [4:0] pulse_q[$];

  always @(posedge Clock) begin
    if (oEnableGenReset) begin
      gen_cnt = 0;
      iEnableDone <= 1'b0;
    end else begin
      gen_cnt = gen_cnt + 1;
      if (gen_cnt == 4) pulse_q.push_back({oLCD_Data, oLCD_RS});
      if (gen_cnt == 12 && !tie_low) iEnableDone <= 1'b1;
    end
  end

  // event monitor
  int   cyc = 0;
  int   done_q[$];
  int   wd_q[$];
  int   err_q[$];
  int   acc_q[$];
  int   egr_low = 0;
  logic prev_done = 1'b0;
  logic prev_ready = 1'b1;
  logic err_egr;
  logic [3:0] err_data;

  always @(negedge Clock) begin
    cyc = cyc + 1;
    if (iEnableDone && !prev_done) done_q.push_back(cyc);
    prev_done = iEnableDone;
    if (oWriteDone === 1'b1) wd_q.push_back(cyc);
    if (oError === 1'b1) begin
      err_q.push_back(cyc);
      err_egr  = oEnableGenReset;
      err_data = oLCD_Data;
    end
    if (prev_ready === 1'b1 && oReady === 1'b0) acc_q.push_back(cyc);
    prev_ready = oReady;
    if (oEnableGenReset === 1'b0) egr_low = egr_low + 1;
  end

  // driver tasks
  task automatic tick();
    @(negedge Clock);
    #1;
  endtask

  task automatic clear_logs();
    pulse_q.delete();
    done_q.delete();
    wd_q.delete();
    err_q.delete();
    acc_q.delete();
    egr_low = 0;
  endtask

  task automatic start_write(input logic [7:0] d, input logic rs);
    int k = 0;
    while (oReady !== 1'b1 && k < BUDGET) begin
      tick();
      k++;
    end
    iData = d;
    iRS = rs;
    iWriteRequest = 1'b1;
    tick();
    iWriteRequest = 1'b0;
  endtask

  task automatic wait_events(input int n_wd, input int n_err, input string name);
    int k = 0;
    while ((wd_q.size() < n_wd || err_q.size() < n_err) && k < BUDGET) begin
      tick();
      k++;
    end
    checks++;
    if (k >= BUDGET) begin
      errors++;
      $display("FAIL %s_timeout: writes=%0d errs=%0d required writes=%0d errs=%0d",
               name, wd_q.size(), err_q.size(), n_wd, n_err);
    end
  endtask

  task automatic check_write(input string name, input logic [7:0] d, input logic rs, input int gap);
    checks++;
    if (pulse_q.size() != 2 || pulse_q[0] !== {d[7:4], rs} || pulse_q[1] !== {d[3:0], rs}) begin
      errors++;
      $display("FAIL %s_pulses: n=%0d got %h/%h required %h/%h", name, pulse_q.size(),
               (pulse_q.size() > 0) ? pulse_q[0] : 5'h0, (pulse_q.size() > 1) ? pulse_q[1] : 5'h0,
               {d[7:4], rs}, {d[3:0], rs});
    end
    checks++;
    if (done_q.size() != 2 || wd_q.size() != 1 || acc_q.size() != 1) begin
      errors++;
      $display("FAIL %s_counts: dones=%0d writes=%0d accepts=%0d required 2/1/1", name,
               done_q.size(), wd_q.size(), acc_q.size());
    end else begin
      checks++;
      if (done_q[0] - acc_q[0] != 13) begin
        errors++;
        $display("FAIL %s_first_done: got %0d required 13", name, done_q[0] - acc_q[0]);
      end
      checks++;
      if (done_q[1] - done_q[0] != NIBBLE + 14) begin
        errors++;
        $display("FAIL %s_nibble_gap: got %0d required %0d", name, done_q[1] - done_q[0], NIBBLE + 14);
      end
      checks++;
      if (wd_q[0] - done_q[1] != gap + 1) begin
        errors++;
        $display("FAIL %s_exec_gap: got %0d required %0d", name, wd_q[0] - done_q[1], gap + 1);
      end
    end
    checks++;
    if (err_q.size() != 0) begin
      errors++;
      $display("FAIL %s_no_error: got %0d error pulses required 0", name, err_q.size());
    end
    tick();
    checks++;
    if (oReady !== 1'b1 || oWriteDone !== 1'b0 || oEnableGenReset !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle: ready=%b done=%b egr=%b required 1 0 1", name, oReady, oWriteDone,
               oEnableGenReset);
    end
  endtask

  // scenario tasks
  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    checks++;
    if (oReady !== 1'b1 || oWriteDone !== 1'b0 || oError !== 1'b0 || oLCD_Data !== 4'h0 ||
        oLCD_RS !== 1'b0 || oLCD_RW !== 1'b0 || oEnableGenReset !== 1'b1 || oDebugState !== 4'd0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b wd=%b err=%b d=%h rs=%b rw=%b egr=%b st=%0d", oReady,
               oWriteDone, oError, oLCD_Data, oLCD_RS, oLCD_RW, oEnableGenReset, oDebugState);
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_data_write();
    clear_logs();
    start_write(8'h41, 1'b1);
    checks++;
    if (oLCD_Data !== 4'h4 || oLCD_RS !== 1'b1 || oLCD_RW !== 1'b0) begin
      errors++;
      $display("FAIL data_setup: d=%h rs=%b rw=%b required 4 1 0", oLCD_Data, oLCD_RS, oLCD_RW);
    end
    wait_events(1, 0, "data");
    check_write("data", 8'h41, 1'b1, EXEC);
  endtask

  task automatic test_clear_cmd();
    clear_logs();
    start_write(8'h01, 1'b0);
    wait_events(1, 0, "clear01");
    check_write("clear01", 8'h01, 1'b0, CLEAR);
    clear_logs();
    start_write(8'h02, 1'b0);
    wait_events(1, 0, "home02");
    check_write("home02", 8'h02, 1'b0, CLEAR);
  endtask

  task automatic test_normal_cmd();
    clear_logs();
    start_write(8'h28, 1'b0);
    wait_events(1, 0, "cmd28");
    check_write("cmd28", 8'h28, 1'b0, EXEC);
    clear_logs();
    start_write(8'h01, 1'b1);
    wait_events(1, 0, "data01");
    check_write("data01", 8'h01, 1'b1, EXEC);
  endtask

  task automatic test_back_to_back();
    int k = 0;
    bit sent = 1'b0;
    clear_logs();
    iData = 8'h41;
    iRS = 1'b1;
    iWriteRequest = 1'b1;
    tick();
    while (!sent && k < BUDGET) begin
      if (oReady === 1'b1) begin
        iData = 8'h28;
        iRS = 1'b0;
        sent = 1'b1;
      end else begin
        iData = 8'($urandom_range(0, 255));
        iRS = 1'($urandom_range(0, 1));
      end
      tick();
      k++;
    end
    iWriteRequest = 1'b0;
    wait_events(2, 0, "b2b");
    checks++;
    if (pulse_q.size() != 4 || pulse_q[0] !== 5'h09 || pulse_q[1] !== 5'h03 ||
        pulse_q[2] !== 5'h04 || pulse_q[3] !== 5'h10) begin
      errors++;
      $display("FAIL b2b_pulses: n=%0d got %h %h %h %h required 09 03 04 10", pulse_q.size(),
               (pulse_q.size() > 0) ? pulse_q[0] : 5'h0, (pulse_q.size() > 1) ? pulse_q[1] : 5'h0,
               (pulse_q.size() > 2) ? pulse_q[2] : 5'h0, (pulse_q.size() > 3) ? pulse_q[3] : 5'h0);
    end
    checks++;
    if (acc_q.size() != 2 || wd_q.size() != 2 || done_q.size() != 4) begin
      errors++;
      $display("FAIL b2b_counts: accepts=%0d writes=%0d dones=%0d required 2/2/4", acc_q.size(),
               wd_q.size(), done_q.size());
    end else begin
      checks++;
      if (acc_q[1] - wd_q[0] != 2 || done_q[2] - wd_q[0] != 15) begin
        errors++;
        $display("FAIL b2b_restart: accept=%0d done=%0d after first write, required 2 and 15",
                 acc_q[1] - wd_q[0], done_q[2] - wd_q[0]);
      end
      checks++;
      if (wd_q[1] - done_q[3] != EXEC + 1) begin
        errors++;
        $display("FAIL b2b_exec_gap: got %0d required %0d", wd_q[1] - done_q[3], EXEC + 1);
      end
    end
    tick();
  endtask

  task automatic test_enable_timeout();
    clear_logs();
    tie_low = 1'b1;
    start_write(8'h41, 1'b1);
    wait_events(0, 1, "timeout");
    checks++;
    if (err_q.size() != 1 || acc_q.size() != 1 || err_q[0] - acc_q[0] != TIMEOUT + 1) begin
      errors++;
      $display("FAIL timeout_latency: errs=%0d got %0d required %0d", err_q.size(),
               (err_q.size() > 0 && acc_q.size() > 0) ? err_q[0] - acc_q[0] : -1, TIMEOUT + 1);
    end
    checks++;
    if (egr_low != TIMEOUT) begin
      errors++;
      $display("FAIL timeout_release_len: got %0d required %0d", egr_low, TIMEOUT);
    end
    checks++;
    if (err_egr !== 1'b1 || err_data !== 4'h0) begin
      errors++;
      $display("FAIL timeout_abort_outputs: egr=%b data=%h required 1 0", err_egr, err_data);
    end
    tick();
    checks++;
    if (oReady !== 1'b1 || oError !== 1'b0 || oDebugState !== 4'd0) begin
      errors++;
      $display("FAIL timeout_idle: rdy=%b err=%b st=%0d required 1 0 0", oReady, oError, oDebugState);
    end
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (wd_q.size() != 0 || err_q.size() != 1) begin
      errors++;
      $display("FAIL timeout_no_done: writes=%0d errs=%0d required 0 1", wd_q.size(), err_q.size());
    end
    tie_low = 1'b0;
  endtask

  task automatic test_reset_mid_gap();
    int k = 0;
    clear_logs();
    start_write(8'h41, 1'b1);
    while (oDebugState !== 4'd3 && k < BUDGET) begin
      tick();
      k++;
    end
    for (int i = 0; i < 5; i++) tick();
    Reset = 1'b1;
    tick();
    checks++;
    if (oReady !== 1'b1 || oWriteDone !== 1'b0 || oError !== 1'b0 || oLCD_Data !== 4'h0 ||
        oLCD_RS !== 1'b0 || oLCD_RW !== 1'b0 || oEnableGenReset !== 1'b1 || oDebugState !== 4'd0) begin
      errors++;
      $display("FAIL midreset_values: rdy=%b wd=%b err=%b d=%h rs=%b rw=%b egr=%b st=%0d", oReady,
               oWriteDone, oError, oLCD_Data, oLCD_RS, oLCD_RW, oEnableGenReset, oDebugState);
    end
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (wd_q.size() != 0 || oDebugState !== 4'd0) begin
      errors++;
      $display("FAIL midreset_abandon: writes=%0d st=%0d required 0 0", wd_q.size(), oDebugState);
    end
    clear_logs();
    start_write(8'h41, 1'b1);
    wait_events(1, 0, "after_reset");
    check_write("after_reset", 8'h41, 1'b1, EXEC);
  endtask

  initial begin
    test_reset();
    test_data_write();
    test_clear_cmd();
    test_normal_cmd();
    test_back_to_back();
    test_enable_timeout();
    test_reset_mid_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
